// File: rtl/warp_mem_arbiter_if.sv
// warp_mem_arbiter_if: request, response and memory-channel bundle for the
// warp memory arbiter.
//   req_*     : NUM_PORTS requesters, flattened per port (lanes within a port)
//   rsp_*     : routed responses (rsp_valid one-hot, payload shared)
//   mem_*     : single registered memory request channel plus response input
// Modports: master = requesters/memory side, slave = arbiter side.
interface warp_mem_arbiter_if #(
  parameter int NUM_PORTS        = 4,
  parameter int THREADS_PER_WARP = 32,
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32,
  parameter int WARP_ID_W        = 6
);
  localparam int TAG_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]                         req_valid;
  logic [NUM_PORTS-1:0]                         req_ready;
  logic [NUM_PORTS*WARP_ID_W-1:0]               req_warp_id;
  logic [NUM_PORTS*THREADS_PER_WARP-1:0]        req_mask;
  logic [NUM_PORTS-1:0]                         req_write_en;
  logic [NUM_PORTS*THREADS_PER_WARP*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*THREADS_PER_WARP*DATA_W-1:0] req_wdata;

  logic [NUM_PORTS-1:0]                         rsp_valid;
  logic [WARP_ID_W-1:0]                         rsp_warp_id;
  logic [THREADS_PER_WARP*DATA_W-1:0]           rsp_data;

  logic                                         mem_req_valid;
  logic                                         mem_ready;
  logic [TAG_W-1:0]                             mem_tag;
  logic [WARP_ID_W-1:0]                         mem_warp_id;
  logic [THREADS_PER_WARP-1:0]                  mem_mask;
  logic                                         mem_write_en;
  logic [THREADS_PER_WARP*ADDR_W-1:0]           mem_addr;
  logic [THREADS_PER_WARP*DATA_W-1:0]           mem_wdata;

  logic                                         mem_rsp_valid;
  logic [TAG_W-1:0]                             mem_rsp_tag;
  logic [WARP_ID_W-1:0]                         mem_rsp_warp_id;
  logic [THREADS_PER_WARP*DATA_W-1:0]           mem_rsp_data;

  modport master (
    output req_valid, req_warp_id, req_mask, req_write_en, req_addr, req_wdata,
    output mem_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_warp_id, mem_rsp_data,
    input  req_ready, rsp_valid, rsp_warp_id, rsp_data,
    input  mem_req_valid, mem_tag, mem_warp_id, mem_mask, mem_write_en, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_warp_id, req_mask, req_write_en, req_addr, req_wdata,
    input  mem_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_warp_id, mem_rsp_data,
    output req_ready, rsp_valid, rsp_warp_id, rsp_data,
    output mem_req_valid, mem_tag, mem_warp_id, mem_mask, mem_write_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/warp_mem_arbiter.sv
// warp_mem_arbiter: round-robin arbiter of NUM_PORTS warp-wide requesters onto
// one registered memory channel, with per-port outstanding limits and tagged
// response routing.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : warp_mem_arbiter_if request/response/memory bundle
//   err_bad_rsp  : sticky flag, set by a response with no matching in-flight
//                  request, cleared only by rst
//   perf_grants, perf_stall : 32-bit wrapping counters, present only when
//                  WARP_MEM_ARB_PERF_EN is defined
// Parameters must match those of the connected interface instance.

// Per-port in-flight request counter.
module warp_mem_arb_cnt #(
  parameter int MAX   = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (inc && !dec) cnt <= cnt + CNT_W'(1);
    else if (dec && !inc) cnt <= cnt - CNT_W'(1);
  end

  assign full = (cnt == CNT_W'(MAX));
endmodule

module warp_mem_arbiter #(
  parameter int NUM_PORTS        = 4,
  parameter int THREADS_PER_WARP = 32,
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32,
  parameter int WARP_ID_W        = 6,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic              clk,
  input  logic              rst,
  warp_mem_arbiter_if.slave bus,
  output logic              err_bad_rsp
`ifdef WARP_MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grants,
  output logic [31:0]       perf_stall
`endif
);
  localparam int TAG_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int A_W   = THREADS_PER_WARP * ADDR_W;
  localparam int D_W   = THREADS_PER_WARP * DATA_W;

  logic [TAG_W-1:0]                 rr_ptr;
  logic [NUM_PORTS-1:0][CNT_W-1:0]  cnt;
  logic [NUM_PORTS-1:0]             cnt_full, cnt_inc, cnt_dec, eligible;
  logic                             stage_free, gnt_vld, rsp_ok;
  logic [TAG_W-1:0]                 gnt_idx;
  int                               scan_idx;

  // Holding stage can take a new request when empty or draining this cycle.
  assign stage_free = !bus.mem_req_valid || bus.mem_ready;
  assign eligible   = bus.req_valid & ~cnt_full;

  // Scan from rr_ptr+1 upward with wrap; first eligible port wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
      if (!gnt_vld && eligible[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = TAG_W'(scan_idx);
      end
    end
    if (!stage_free || rst) gnt_vld = 1'b0;
  end

  // A response is legal only if its port has something in flight; compare
  // per port so out-of-range tags never index the counter array.
  always_comb begin
    rsp_ok = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (bus.mem_rsp_tag == TAG_W'(p) && cnt[p] != '0) rsp_ok = bus.mem_rsp_valid;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign cnt_inc[p] = gnt_vld && (gnt_idx == TAG_W'(p));
    assign cnt_dec[p] = rsp_ok && (bus.mem_rsp_tag == TAG_W'(p));

    warp_mem_arb_cnt #(.MAX(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (cnt_inc[p]),
      .dec  (cnt_dec[p]),
      .cnt  (cnt[p]),
      .full (cnt_full[p])
    );
  end

  // One-hot to the granted port; already gated by rst and stage_free.
  assign bus.req_ready = cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= TAG_W'(NUM_PORTS - 1);
    else if (gnt_vld) rr_ptr <= gnt_idx;
  end

  // Holding stage: payload only moves when the stage is free and a grant lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_req_valid <= 1'b0;
      bus.mem_tag       <= '0;
      bus.mem_warp_id   <= '0;
      bus.mem_mask      <= '0;
      bus.mem_write_en  <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
    end else if (stage_free) begin
      bus.mem_req_valid <= gnt_vld;
      if (gnt_vld) begin
        bus.mem_tag      <= gnt_idx;
        bus.mem_warp_id  <= bus.req_warp_id[gnt_idx*WARP_ID_W +: WARP_ID_W];
        bus.mem_mask     <= bus.req_mask[gnt_idx*THREADS_PER_WARP +: THREADS_PER_WARP];
        bus.mem_write_en <= bus.req_write_en[gnt_idx];
        bus.mem_addr     <= bus.req_addr[gnt_idx*A_W +: A_W];
        bus.mem_wdata    <= bus.req_wdata[gnt_idx*D_W +: D_W];
      end
    end
  end

  // Response register: cnt_dec is already the one-hot strobe for a legal response.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid   <= '0;
      bus.rsp_warp_id <= '0;
      bus.rsp_data    <= '0;
      err_bad_rsp     <= 1'b0;
    end else begin
      bus.rsp_valid <= cnt_dec;
      if (rsp_ok) begin
        bus.rsp_warp_id <= bus.mem_rsp_warp_id;
        bus.rsp_data    <= bus.mem_rsp_data;
      end
      if (bus.mem_rsp_valid && !rsp_ok) err_bad_rsp <= 1'b1;
    end
  end

`ifdef WARP_MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants <= '0;
      perf_stall  <= '0;
    end else begin
      if (gnt_vld) perf_grants <= perf_grants + 32'd1;
      if (|bus.req_valid && !gnt_vld) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule
